// File: rtl/shift_sequencer_pkg.sv
// Shared settings for the shift sequencer: default widths, shift-type and
// FSM state encodings.
package shift_sequencer_pkg;

  localparam int DEF_WORD_WIDTH            = 32;
  localparam int DEF_SHIFTER_OPERAND_WIDTH = 12;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate of one word by the selected type.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] value,
  input  shift_t                sh_type,
  output logic [WORD_WIDTH-1:0] value_out
);

  logic signed [WORD_WIDTH-1:0] value_s;

  assign value_s = value;

  always_comb begin
    value_out = value;
    case (sh_type)
      SH_LSL:  value_out = {value[WORD_WIDTH-2:0], 1'b0};
      SH_LSR:  value_out = {1'b0, value[WORD_WIDTH-1:1]};
      SH_ASR:  value_out = value_s >>> 1;
      SH_ROR:  value_out = {value[0], value[WORD_WIDTH-1:1]};
      default: value_out = value;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequential operand-2 generator: loads an operand, shifts it one bit per
// cycle under an IDLE/SHIFT/DONE FSM and presents the result with a done pulse.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WORD_WIDTH            = DEF_WORD_WIDTH,
  parameter int SHIFTER_OPERAND_WIDTH = DEF_SHIFTER_OPERAND_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             flush,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
  input  logic                             imm,
  input  logic                             is_for_memory,
  input  logic [WORD_WIDTH-1:0]            val_Rm,
  output logic                             busy,
  output logic                             done,
  output logic [WORD_WIDTH-1:0]            val2_out
);

  state_t                state_q, state_d;
  logic [4:0]            cnt_q;
  logic [WORD_WIDTH-1:0] work_q;
  logic [WORD_WIDTH-1:0] val2_q;
  shift_t                op_q;

  logic [WORD_WIDTH-1:0] load_val;
  logic [4:0]            load_cnt;
  shift_t                load_op;
  logic [WORD_WIDTH-1:0] step_val;
  logic                  accept;

  assign accept = (state_q == ST_IDLE) && start && !flush;

  // Operand decode; rotated immediates always rotate right by an even amount.
  always_comb begin
    load_val = val_Rm;
    load_cnt = shifter_operand[11:7];
    load_op  = shift_t'(shifter_operand[6:5]);
    if (is_for_memory) begin
      load_val = WORD_WIDTH'(shifter_operand);
      load_cnt = '0;
      load_op  = SH_LSL;
    end else if (imm) begin
      load_val = WORD_WIDTH'(shifter_operand[7:0]);
      load_cnt = {shifter_operand[11:8], 1'b0};
      load_op  = SH_ROR;
    end
  end

  shift_step #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shift_step (
    .value     (work_q),
    .sh_type   (op_q),
    .value_out (step_val)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (load_cnt != 5'd0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (cnt_q == 5'd1) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      val2_q  <= '0;
      op_q    <= SH_LSL;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              work_q <= load_val;
              cnt_q  <= load_cnt;
              op_q   <= load_op;
            end
          end
          ST_SHIFT: begin
            work_q <= step_val;
            cnt_q  <= cnt_q - 5'd1;
          end
          ST_DONE:  val2_q <= work_q;
          default:  cnt_q  <= '0;
        endcase
      end
    end
  end

  // The result is visible in the DONE cycle itself; a flush there cancels it.
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE) && !flush;
  assign val2_out = done ? work_q : val2_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic
// reference model.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [11:0] shifter_operand;
  logic        imm;
  logic        is_for_memory;
  logic [31:0] val_Rm;
  logic        busy;
  logic        done;
  logic [31:0] val2_out;

  int          n_cmp;
  int          n_err;
  logic [31:0] prev_v;

  shift_sequencer #(
    .WORD_WIDTH            (32),
    .SHIFTER_OPERAND_WIDTH (12)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .flush           (flush),
    .shifter_operand (shifter_operand),
    .imm             (imm),
    .is_for_memory   (is_for_memory),
    .val_Rm          (val_Rm),
    .busy            (busy),
    .done            (done),
    .val2_out        (val2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] model(input logic [11:0] so, input logic im,
                                        input logic mem, input logic [31:0] rm,
                                        output int lat);
    logic [31:0] r;
    int          n;
    if (mem) begin
      n = 0;
      r = {20'd0, so};
    end else if (im) begin
      n = 2 * int'(so[11:8]);
      r = rotr({24'd0, so[7:0]}, n);
    end else begin
      n = int'(so[11:7]);
      case (so[6:5])
        2'b00:   r = rm << n;
        2'b01:   r = rm >> n;
        2'b10:   r = $signed(rm) >>> n;
        default: r = rotr(rm, n);
      endcase
    end
    lat = n + 1;
    return r;
  endfunction

  task automatic scramble();
    shifter_operand = 12'($urandom);
    imm             = 1'($urandom);
    is_for_memory   = 1'($urandom);
    val_Rm          = $urandom;
  endtask

  task automatic do_op(input string tag, input logic [11:0] so, input logic im,
                       input logic mem, input logic [31:0] rm, input bit poke);
    logic [31:0] exp_v, got_v;
    int          lat, dcyc, nd;
    bit          poke_eff;
    exp_v    = model(so, im, mem, rm, lat);
    poke_eff = poke && (lat > 5);
    @(negedge clk);
    shifter_operand = so;
    imm             = im;
    is_for_memory   = mem;
    val_Rm          = rm;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    dcyc  = -1;
    nd    = 0;
    got_v = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (cyc == lat + 1) check({tag, "_idle"}, 32'(busy), 32'd0);
      if (done) begin
        nd++;
        if (dcyc < 0) begin
          dcyc  = cyc;
          got_v = val2_out;
        end
      end
      start = poke_eff && (cyc == 3);
      if (start) scramble();
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(dcyc), 32'(lat));
    check({tag, "_ndone"}, 32'(nd), 32'd1);
    check({tag, "_val"}, got_v, exp_v);
    check({tag, "_hold"}, val2_out, exp_v);
    prev_v = exp_v;
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nd;
    n_cmp  = 0;
    n_err  = 0;
    prev_v = '0;
    rst    = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    shifter_operand = '0;
    imm    = 1'b0;
    is_for_memory = 1'b0;
    val_Rm = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_val", val2_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_op("mem_abc", 12'hABC, 1'b0, 1'b1, $urandom, 1'b0);
    do_op("imm_4ff", 12'h4FF, 1'b1, 1'b0, $urandom, 1'b0);
    do_op("asr1", 12'h0C0, 1'b0, 1'b0, 32'h8000_0001, 1'b0);
    do_op("ror1", 12'h0E0, 1'b0, 1'b0, 32'h8000_0001, 1'b0);
    do_op("lsr1", 12'h0A0, 1'b0, 1'b0, 32'h8000_0001, 1'b0);
    do_op("lsl31", 12'hF80, 1'b0, 1'b0, 32'h0000_0003, 1'b1);
    do_op("lsr31", 12'hFA0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    do_op("asr31", 12'hFC0, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
    do_op("reg0", 12'h020, 1'b0, 1'b0, 32'h1234_5678, 1'b0);

    // Flush three cycles into a 10-step shift.
    @(negedge clk);
    shifter_operand = 12'h500;
    imm = 1'b0;
    is_for_memory = 1'b0;
    val_Rm = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_done", 32'(done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_keep", val2_out, prev_v);
    count_dones(20, nd);
    check("fl_nodone", 32'(nd), 32'd0);
    do_op("after_fl", 12'h3E5, 1'b1, 1'b0, $urandom, 1'b0);

    // Flush arriving in the DONE cycle cancels the result.
    @(negedge clk);
    shifter_operand = 12'h123;
    is_for_memory = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    #1;
    check("fld_done", 32'(done), 32'd0);
    check("fld_keep", val2_out, prev_v);
    @(negedge clk);
    flush = 1'b0;
    check("fld_busy", 32'(busy), 32'd0);
    check("fld_keep2", val2_out, prev_v);

    // Flush together with start in IDLE.
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flst_busy", 32'(busy), 32'd0);
    count_dones(5, nd);
    check("flst_nodone", 32'(nd), 32'd0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    shifter_operand = 12'hF80;
    is_for_memory = 1'b0;
    imm = 1'b0;
    val_Rm = 32'hDEAD_BEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_val", val2_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    prev_v = '0;
    count_dones(40, nd);
    check("mrst_nodone", 32'(nd), 32'd0);
    check("mrst_val2", val2_out, 32'd0);

    for (int k = 0; k < 40; k++) begin
      logic [11:0] so;
      logic        im, mem;
      so  = 12'($urandom);
      im  = 1'($urandom);
      mem = ($urandom_range(0, 5) == 0);
      do_op("rnd", so, im, mem, $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
